// File: rtl/multdiv_pkg.sv
// rtl/multdiv_pkg.sv - shared types and constants for the sequential multiply/divide unit
package multdiv_pkg;

  localparam int                WIDTH       = 32;
  localparam logic [4:0]        ITER_LAST   = 5'd31;
  localparam logic [WIDTH-1:0]  ZERO_RESULT = '0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Unsigned magnitude of a two's-complement value; INT_MIN maps to 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (ZERO_RESULT - v) : v;
  endfunction

endpackage

// File: rtl/multdiv_datapath.sv
// rtl/multdiv_datapath.sv - 64-bit shift-add / restoring-divide accumulator driven by FSM strobes
module multdiv_datapath
  import multdiv_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 load,
  input  logic [WIDTH-1:0]     load_lo,
  input  logic [WIDTH-1:0]     load_opnd,
  input  logic                 step_mul,
  input  logic                 step_div,
  output logic [2*WIDTH-1:0]   acc_next
);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;

  // Next accumulator: multiply adds opnd into the high half then shifts right;
  // divide shifts left and keeps the trial subtraction when it does not borrow.
  always_comb begin
    acc_d  = acc_q;
    opnd_d = opnd_q;
    sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
    diff   = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_q};
    if (load) begin
      acc_d  = {ZERO_RESULT, load_lo};
      opnd_d = load_opnd;
    end else if (step_mul) begin
      if (acc_q[0]) acc_d = {sum, acc_q[WIDTH-1:1]};
      else          acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
    end else if (step_div) begin
      if (!diff[WIDTH]) acc_d = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      else              acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
    end
    acc_next = acc_d;
  end

  // Accumulator and operand registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc_q  <= '0;
      opnd_q <= '0;
    end else begin
      acc_q  <= acc_d;
      opnd_q <= opnd_d;
    end
  end

endmodule

// File: rtl/multdiv_seq.sv
// rtl/multdiv_seq.sv - sequential signed multiply/divide unit; MULTDIV_OVF_EXC_EN enables overflow reporting
module multdiv_seq
  import multdiv_pkg::*;
(
  input  logic               clock,
  input  logic               reset_n,
  input  logic               ctrl_mult,
  input  logic               ctrl_div,
  input  logic [WIDTH-1:0]   data_a,
  input  logic [WIDTH-1:0]   data_b,
  output logic [WIDTH-1:0]   result,
  output logic               exception,
  output logic               result_ready,
  output logic               stall
);

  state_e             state_q, state_d;
  logic [4:0]         cnt_q, cnt_d;
  logic               neg_q, neg_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               exc_q, exc_d;
  logic               ready_q, ready_d;

  logic               accept;
  logic               dp_load;
  logic [WIDTH-1:0]   mag_a, mag_b, load_lo, load_opnd;
  logic [2*WIDTH-1:0] acc_next, product;
  logic [WIDTH-1:0]   quotient;
  logic               ovf_mul, ovf_div;

  multdiv_datapath u_datapath (
    .clock     (clock),
    .reset_n   (reset_n),
    .load      (dp_load),
    .load_lo   (load_lo),
    .load_opnd (load_opnd),
    .step_mul  (state_q == ST_MUL),
    .step_div  (state_q == ST_DIV),
    .acc_next  (acc_next)
  );

  // Next-state, counter, sign and registered-output logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    result_d = result_q;
    exc_d    = exc_q;
    ready_d  = 1'b0;

    accept    = (ctrl_mult | ctrl_div) & ((state_q == ST_IDLE) | (state_q == ST_DONE));
    dp_load   = accept;
    mag_a     = magnitude(data_a);
    mag_b     = magnitude(data_b);
    load_lo   = ctrl_mult ? mag_b : mag_a;
    load_opnd = ctrl_mult ? mag_a : mag_b;

    product  = neg_q ? ('0 - acc_next) : acc_next;
    quotient = neg_q ? (ZERO_RESULT - acc_next[WIDTH-1:0]) : acc_next[WIDTH-1:0];
    ovf_mul  = product[2*WIDTH-1:WIDTH] != {WIDTH{product[WIDTH-1]}};
    // Only INT_MIN / -1 yields an unnegated quotient magnitude of 2^(WIDTH-1).
    ovf_div  = ~neg_q & acc_next[WIDTH-1];

    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (accept) begin
          result_d = ZERO_RESULT;
          exc_d    = 1'b0;
          cnt_d    = '0;
          neg_d    = data_a[WIDTH-1] ^ data_b[WIDTH-1];
          if (ctrl_mult) begin
            state_d = ST_MUL;
          end else if (data_b == ZERO_RESULT) begin
            state_d = ST_DONE;
            exc_d   = 1'b1;
            ready_d = 1'b1;
          end else begin
            state_d = ST_DIV;
          end
        end
      end
      ST_MUL, ST_DIV: begin
        if (cnt_q == ITER_LAST) begin
          state_d  = ST_DONE;
          ready_d  = 1'b1;
          result_d = (state_q == ST_MUL) ? product[WIDTH-1:0] : quotient;
`ifdef MULTDIV_OVF_EXC_EN
          exc_d    = (state_q == ST_MUL) ? ovf_mul : ovf_div;
`else
          exc_d    = 1'b0;
`endif
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM and output registers; reset abandons any operation in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      result_q <= ZERO_RESULT;
      exc_q    <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      ready_q  <= ready_d;
    end
  end

  // Stall covers the acceptance cycle and every iteration cycle.
  always_comb begin
    stall = reset_n & (accept | (state_q == ST_MUL) | (state_q == ST_DIV));
  end

  assign result       = result_q;
  assign exception    = exc_q;
  assign result_ready = ready_q;

endmodule

// File: tb/tb_multdiv_seq.sv
// tb/tb_multdiv_seq.sv - scoreboard bench for multdiv_seq
module tb_multdiv_seq;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        ctrl_mult = 1'b0;
  logic        ctrl_div = 1'b0;
  logic [31:0] data_a = '0;
  logic [31:0] data_b = '0;
  logic [31:0] result;
  logic        exception;
  logic        result_ready;
  logic        stall;

  typedef struct {
    logic [31:0] res;
    logic        exc;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  multdiv_seq dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .ctrl_mult    (ctrl_mult),
    .ctrl_div     (ctrl_div),
    .data_a       (data_a),
    .data_b       (data_b),
    .result       (result),
    .exception    (exception),
    .result_ready (result_ready),
    .stall        (stall)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input logic m, input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint p;
    logic [31:0] lo;
    e.lat = 33;
    if (m) begin
      p = longint'($signed(a)) * longint'($signed(b));
    end else if (b == 32'd0) begin
      p = 0;
      e.lat = 1;
    end else begin
      p = longint'($signed(a)) / longint'($signed(b));
    end
    lo    = p[31:0];
    e.res = lo;
`ifdef MULTDIV_OVF_EXC_EN
    e.exc = (p != longint'($signed(lo)));
`else
    e.exc = 1'b0;
`endif
    if (!m && b == 32'd0) e.exc = 1'b1;
    return e;
  endfunction

  // Drive a start in the current cycle (cycle 0); accepted on the next rising edge.
  task automatic issue(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
    ctrl_mult = m;
    ctrl_div  = d;
    data_a    = a;
    data_b    = b;
    sb.push_back(model(m, a, b));
    #1;
    chk("stall_cycle0", {31'd0, stall}, 32'd1);
    @(posedge clock);
    #1;
    ctrl_mult = 1'b0;
    ctrl_div  = 1'b0;
    data_a    = $urandom;
    data_b    = $urandom;
  endtask

  // Wait for result_ready, checking stall every busy cycle; poke>0 pulses ctrl_div in that cycle.
  task automatic await(input string tag, input int poke);
    exp_t e;
    int   lat;
    bit   seen;
    lat  = 0;
    seen = 1'b0;
    e    = sb.pop_front();
    while (lat < 40 && !seen) begin
      @(negedge clock);
      lat++;
      if (poke > 0) ctrl_div = (lat == poke);
      #1;
      if (result_ready) begin
        seen = 1'b1;
      end else begin
        chk({tag, "_stall_busy"}, {31'd0, stall}, 32'd1);
        if (lat == 1) begin
          chk({tag, "_result_cleared"}, result, 32'd0);
          chk({tag, "_exc_cleared"}, {31'd0, exception}, 32'd0);
        end
      end
    end
    ctrl_div = 1'b0;
    #1;
    chk({tag, "_latency"}, lat, e.lat);
    chk({tag, "_result"}, result, e.res);
    chk({tag, "_exception"}, {31'd0, exception}, {31'd0, e.exc});
    chk({tag, "_stall_done"}, {31'd0, stall}, 32'd0);
  endtask

  // One idle cycle after DONE: ready drops, result and exception hold.
  task automatic check_hold(input string tag, input logic [31:0] res, input logic exc);
    @(negedge clock);
    #1;
    chk({tag, "_ready_pulse"}, {31'd0, result_ready}, 32'd0);
    chk({tag, "_hold_result"}, result, res);
    chk({tag, "_hold_exc"}, {31'd0, exception}, {31'd0, exc});
    chk({tag, "_idle_stall"}, {31'd0, stall}, 32'd0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    exp_t        ex;

    // reset state, with a start request held during reset
    repeat (2) @(negedge clock);
    ctrl_mult = 1'b1;
    #1;
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_exception", {31'd0, exception}, 32'd0);
    chk("rst_ready", {31'd0, result_ready}, 32'd0);
    ctrl_mult = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;

    // 7 * -3 directly after reset release
    issue(1'b1, 1'b0, 32'd7, -32'sd3);
    await("mul_7_m3", 0);
    check_hold("mul_7_m3", 32'hFFFF_FFEB, 1'b0);

    issue(1'b0, 1'b1, -32'sd100, 32'd7);
    await("div_m100_7", 0);

    // start accepted straight from DONE
    issue(1'b0, 1'b1, 32'd5, 32'd0);
    await("div_by_zero", 0);
    check_hold("div_by_zero", 32'd0, 1'b1);

    issue(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000);
    await("mul_ovf", 0);

    issue(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    await("div_intmin", 0);

    // both requests: multiply wins; a divide request mid-multiply is ignored
    issue(1'b1, 1'b1, 32'd6, 32'd2);
    await("mul_priority", 5);

    // reset at cycle 10 of a multiply
    issue(1'b1, 1'b0, 32'h1234_5678, 32'h0000_0FFF);
    repeat (10) @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk("midrst_result", result, 32'd0);
    chk("midrst_exception", {31'd0, exception}, 32'd0);
    chk("midrst_ready", {31'd0, result_ready}, 32'd0);
    chk("midrst_stall", {31'd0, stall}, 32'd0);
    ex = sb.pop_front();
    @(negedge clock);
    reset_n = 1'b1;
    issue(1'b0, 1'b1, 32'd100, 32'd7);
    await("div_after_rst", 0);

    // signed boundary and random operands
    issue(1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
    await("mul_intmin_m1", 0);
    issue(1'b0, 1'b1, 32'h7FFF_FFFF, 32'h8000_0000);
    await("div_max_min", 0);
    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = (i % 2 == 0) ? $urandom : ($urandom % 32'd1000) + 32'd1;
      issue(i[0], ~i[0], ra, rb);
      await("random_op", 0);
    end

    if (sb.size() != 0) chk("scoreboard_empty", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/multdiv_seq.md
MULTDIV_SEQ -- requirements
Module: multdiv_seq

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 WIDTH, 32, operand and result width; only 32 is supported.
REQ-003 clock  in  1  rising-edge clock.
REQ-004 reset_n  in  1  asynchronous active-low reset.
REQ-005 ctrl_mult  in  1  one-cycle start request for signed multiply.
REQ-006 ctrl_div  in  1  one-cycle start request for signed divide.
REQ-007 data_a  in  32  multiplicand / dividend, sampled only on start acceptance.
REQ-008 data_b  in  32  multiplier / divisor, sampled only on start acceptance.
REQ-009 result  out  32  low 32 bits of product, or quotient.
REQ-010 exception  out  1  error flag, valid while result_ready is high.
REQ-011 result_ready  out  1  one-cycle completion pulse.
REQ-012 stall  out  1  pipeline hold request to the processor control path.

Function
REQ-013 The FSM SHALL have four states: IDLE, MUL, DIV and DONE.
REQ-014 Start SHALL be accepted only in IDLE or DONE; a request in MUL or DIV SHALL be ignored.
REQ-015 If ctrl_mult and ctrl_div are both high, the multiply SHALL win.
REQ-016 On acceptance (cycle 0), operands SHALL be latched, the 5-bit iteration counter cleared, and the state set to MUL or DIV.
REQ-017 MUL SHALL run radix-2 shift-add on operand magnitudes for exactly 32 cycles (cycles 1..32), apply sign correction, and enter DONE at cycle 33.
REQ-018 DIV SHALL run restoring division on magnitudes for 32 cycles.
REQ-019 The quotient SHALL truncate toward zero and be negated when the operand signs differ; the remainder SHALL be discarded.
REQ-020 A divisor of 0 SHALL skip iteration: DONE at cycle 1, result=0, exception=1.
REQ-021 In DONE, result_ready SHALL be 1 for exactly one cycle.
REQ-022 From DONE, the next state SHALL be IDLE, or MUL/DIV if a new start arrives in that cycle.
REQ-023 result and exception SHALL hold their DONE values until the next acceptance, which clears both.
REQ-024 stall SHALL be combinational: high in the acceptance cycle and throughout MUL/DIV, low in IDLE and DONE.
REQ-025 The counter SHALL terminate at 31 and SHALL never wrap into a new operation.
REQ-026 0x80000000 / 0xFFFFFFFF SHALL yield result 0x80000000; exception is defined by REQ-031.

Reset
REQ-027 reset_n low SHALL force IDLE immediately, including mid-operation, abandoning the operation.
REQ-028 During reset, result=0, exception=0, result_ready=0, stall=0, and the counter and operand registers are cleared.
REQ-029 The first rising edge after reset_n deasserts SHALL accept a start normally.

Configuration
REQ-030 Macro MULTDIV_OVF_EXC_EN SHALL select arithmetic-overflow reporting.
REQ-031 With MULTDIV_OVF_EXC_EN defined, exception=1 in DONE when the 64-bit signed product is not the sign-extension of its low 32 bits, or for the INT_MIN/-1 division.
REQ-032 Without MULTDIV_OVF_EXC_EN, exception SHALL reflect divide-by-zero only; overflowing results wrap silently.
REQ-033 Result values and latency SHALL be identical with and without MULTDIV_OVF_EXC_EN.

Structure
REQ-034 Package multdiv_pkg SHALL hold the state enum, WIDTH=32, ITER_LAST=5'd31 and the zero-result constant.
REQ-035 Sub-module multdiv_datapath SHALL contain the 64-bit accumulator/shift registers and add/subtract logic, driven by FSM strobes.
REQ-036 multdiv_seq SHALL own the FSM, counter, sign correction and the stall/ready/exception logic.

Verification
REQ-037 ctrl_mult, A=7, B=-3 -> stall high cycles 0..32; result 0xFFFFFFEB with result_ready=1 at cycle 33; exception=0.
REQ-038 ctrl_div, A=-100, B=7 -> result 0xFFFFFFF2 (-14) at cycle 33; exception=0.
REQ-039 ctrl_div, A=5, B=0 -> result_ready at cycle 1, result 0, exception=1; stall high in cycle 0 only.
REQ-040 ctrl_mult, A=B=0x00010000 -> result 0 at cycle 33; exception=1 with MULTDIV_OVF_EXC_EN, 0 without.
REQ-041 reset_n low at cycle 10 of a multiply -> all outputs 0 immediately; a new start (100/7) gives result 14 at cycle 33.
REQ-042 ctrl_mult and ctrl_div together, A=6, B=2 -> result 12; any ctrl_div during MUL is ignored.
